x_dl_sched: RTL and testbench

X_DL_SCHED -- requirements
Module: x_dl_sched

---
 rtl/x_dl_sched_pkg.sv | 18 +
 rtl/x_popcount.sv | 18 +
 rtl/x_dl_sched.sv | 189 ++++++++++++++++++
 tb/tb_x_dl_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_dl_sched_pkg.sv
// Shared types and constants for the delay-line sample scheduler.
package x_dl_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARG     = 3'd1,
    ST_RAW     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4
  } state_e;

  localparam logic [7:0] CMD_RAW = 8'h52;  // 'R'
  localparam logic [7:0] CMD_SUM = 8'h53;  // 'S'

  // 256 samples * 32 ones = 8192 needs 14 bits.
  localparam int ACC_W = 14;

endpackage

// File: rtl/x_popcount.sv
// Combinational population count of a delay-line thermometer sample.
module x_popcount #(
  parameter  int p_dl_width = 32,
  localparam int CW         = $clog2(p_dl_width + 1)
) (
  input  logic [p_dl_width-1:0] i_vec,
  output logic [CW-1:0]         o_cnt
);

  // Plain adder chain; synthesis rebalances it into a tree.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < p_dl_width; i++) begin
      o_cnt = o_cnt + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/x_dl_sched.sv
// Delay-line sampling scheduler driven by UART command bytes.
//   'R'       -> latch one sample, reply with 4 bytes MSB first.
//   'S', N    -> sum popcounts of N samples (N=0 means 256), reply with
//                the 16-bit sum big-endian.
// Optional build macro X_DL_SCHED_MINMAX_EN: also track min/max popcount
// over the capture and append them to the 'S' reply (4 bytes total).
module x_dl_sched
  import x_dl_sched_pkg::*;
#(
  parameter int p_dl_width = 32,
  parameter int p_cnt_w    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  output logic                  o_valid,
  input  logic                  i_accept,
  output logic [7:0]            o_data,
  input  logic                  i_dl_valid,
  input  logic [p_dl_width-1:0] i_dl,
  output logic                  o_busy
);

  localparam int PC_W = $clog2(p_dl_width + 1);
  localparam logic [p_cnt_w:0] CNT_FULL = {1'b1, {p_cnt_w{1'b0}}};
  localparam logic [p_cnt_w:0] CNT_ONE  = (p_cnt_w + 1)'(1);
`ifdef X_DL_SCHED_MINMAX_EN
  localparam logic [1:0] SUM_LAST = 2'd3;
`else
  localparam logic [1:0] SUM_LAST = 2'd1;
`endif

  state_e                state_q, state_d;
  logic [p_cnt_w:0]      cnt_q, cnt_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [p_dl_width-1:0] raw_q, raw_d;
  logic [1:0]            idx_q, idx_d;
  logic                  kind_raw_q, kind_raw_d;
`ifdef X_DL_SCHED_MINMAX_EN
  logic [PC_W-1:0]       min_q, min_d;
  logic [PC_W-1:0]       max_q, max_d;
`endif

  logic [PC_W-1:0]  pc;
  logic [p_cnt_w:0] arg_ext;
  logic [1:0]       last_idx;
  logic [31:0]      raw32;
  logic [15:0]      sum16;
  logic [7:0]       byte_sel;

  x_popcount #(.p_dl_width(p_dl_width)) u_popcount (
    .i_vec (i_dl),
    .o_cnt (pc)
  );

  assign arg_ext  = (p_cnt_w + 1)'(i_data);
  assign last_idx = kind_raw_q ? 2'd3 : SUM_LAST;
  assign raw32    = 32'(raw_q);
  assign sum16    = 16'(acc_q);

  // Response byte selection by command kind and byte index.
  always_comb begin
    byte_sel = 8'h00;
    if (kind_raw_q) begin
      case (idx_q)
        2'd0:    byte_sel = raw32[31:24];
        2'd1:    byte_sel = raw32[23:16];
        2'd2:    byte_sel = raw32[15:8];
        default: byte_sel = raw32[7:0];
      endcase
    end else begin
      case (idx_q)
        2'd0:    byte_sel = sum16[15:8];
        2'd1:    byte_sel = sum16[7:0];
`ifdef X_DL_SCHED_MINMAX_EN
        2'd2:    byte_sel = 8'(min_q);
        default: byte_sel = 8'(max_q);
`else
        default: byte_sel = 8'h00;
`endif
      endcase
    end
  end

  assign o_valid = (state_q == ST_SEND);
  assign o_data  = (state_q == ST_SEND) ? byte_sel : 8'h00;
  assign o_busy  = (state_q != ST_IDLE);

  // Next-state and datapath update; bytes outside IDLE/ARG are dropped
  // simply by not being looked at.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    raw_d      = raw_q;
    idx_d      = idx_q;
    kind_raw_d = kind_raw_q;
`ifdef X_DL_SCHED_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (i_data == CMD_RAW) begin
            state_d    = ST_RAW;
            kind_raw_d = 1'b1;
          end else if (i_data == CMD_SUM) begin
            state_d    = ST_ARG;
            kind_raw_d = 1'b0;
          end
        end
      end
      ST_ARG: begin
        // Samples in this cycle are ignored: counting starts next cycle.
        if (i_valid) begin
          cnt_d   = (arg_ext == '0) ? CNT_FULL : arg_ext;
          acc_d   = '0;
`ifdef X_DL_SCHED_MINMAX_EN
          min_d   = '1;
          max_d   = '0;
`endif
          state_d = ST_CAPTURE;
        end
      end
      ST_RAW: begin
        if (i_dl_valid) begin
          raw_d   = i_dl;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end
      ST_CAPTURE: begin
        if (i_dl_valid) begin
          acc_d = acc_q + ACC_W'(pc);
          cnt_d = cnt_q - CNT_ONE;
`ifdef X_DL_SCHED_MINMAX_EN
          if (pc < min_q) min_d = pc;
          if (pc > max_q) max_d = pc;
`endif
          if (cnt_q == CNT_ONE) begin
            idx_d   = 2'd0;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (i_accept) begin
          if (idx_q == last_idx) begin
            idx_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      raw_q      <= '0;
      idx_q      <= 2'd0;
      kind_raw_q <= 1'b0;
`ifdef X_DL_SCHED_MINMAX_EN
      min_q      <= '0;
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      raw_q      <= raw_d;
      idx_q      <= idx_d;
      kind_raw_q <= kind_raw_d;
`ifdef X_DL_SCHED_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

endmodule

// File: tb/tb_x_dl_sched.sv
// Scoreboard bench for x_dl_sched: stimulus tasks push expected reply
// bytes, a negedge monitor pops and compares on every transfer.
module tb_x_dl_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_valid;
  logic        i_accept = 1'b0;
  logic [7:0]  o_data;
  logic        i_dl_valid = 1'b0;
  logic [31:0] i_dl = 32'h0;
  logic        o_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit hold     = 1'b0;

  logic [7:0] sb[$];

  x_dl_sched #(.p_dl_width(32), .p_cnt_w(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_accept   (i_accept),
    .o_data     (o_data),
    .i_dl_valid (i_dl_valid),
    .i_dl       (i_dl),
    .o_busy     (o_busy)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Receiver back-pressure: random accept unless hold is requested.
  always @(posedge i_clk) begin
    #1;
    i_accept = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: stability while stalled, byte compare on each transfer.
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  always @(negedge i_clk) begin
    if (i_rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, pend_data);
      end
      if (o_valid && i_accept) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", o_data);
        end else begin
          chk("resp_byte", o_data, sb.pop_front());
        end
        pend = 1'b0;
      end else if (o_valid) begin
        pend = 1'b1;
        pend_data = o_data;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_valid = 1'b1;
    i_data  = b;
    tick();
    i_valid = 1'b0;
  endtask

  // One idle-or-noise cycle: optional dropped junk byte, often 'R'.
  task automatic gap(input bit noisy);
    if (noisy && $urandom_range(0, 1) == 1) begin
      i_valid = 1'b1;
      i_data  = ($urandom_range(0, 1) == 1) ? 8'h52 : 8'($urandom());
    end
    tick();
    i_valid = 1'b0;
  endtask

  // Reference: sum/min/max of popcounts, reply bytes big-endian.
  task automatic push_sum(input logic [31:0] smp[$]);
    int s, mn, mx, c;
    s = 0; mn = 1000; mx = -1;
    foreach (smp[k]) begin
      c = $countones(smp[k]);
      s += c;
      if (c < mn) mn = c;
      if (c > mx) mx = c;
    end
    sb.push_back(8'((s / 256) % 256));
    sb.push_back(8'(s % 256));
`ifdef X_DL_SCHED_MINMAX_EN
    sb.push_back(8'(mn));
    sb.push_back(8'(mx));
`endif
  endtask

  task automatic do_sum(input logic [31:0] smp[$], input bit noisy, input bit expect_reply);
    if (expect_reply) push_sum(smp);
    send_byte(8'h53);
    if (noisy) repeat ($urandom_range(0, 2)) tick();
    // A sample coincident with the count byte must not be counted.
    i_valid    = 1'b1;
    i_data     = 8'(smp.size());
    i_dl_valid = noisy;
    i_dl       = $urandom();
    tick();
    i_valid    = 1'b0;
    i_dl_valid = 1'b0;
    foreach (smp[k]) begin
      if (noisy) repeat ($urandom_range(0, 2)) gap(1'b1);
      i_dl_valid = 1'b1;
      i_dl       = smp[k];
      if (noisy && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b1;
        i_data  = 8'h52;
      end
      tick();
      i_dl_valid = 1'b0;
      i_valid    = 1'b0;
    end
  endtask

  task automatic do_raw(input logic [31:0] d, input bit noisy);
    sb.push_back(d[31:24]);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
    send_byte(8'h52);
    if (noisy) repeat ($urandom_range(0, 2)) gap(1'b1);
    i_dl_valid = 1'b1;
    i_dl       = d;
    tick();
    i_dl_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (!o_busy && sb.size() == 0) break;
      tick();
    end
    if (k == 3000) begin
      n_checks++;
      $display("FAIL %s_timeout: busy=%0d pending=%0d expected idle", name, o_busy, sb.size());
    end else begin
      chk({name, "_busy"}, o_busy, 0);
    end
  endtask

  task automatic pulse_reset(input string name);
    i_rst = 1'b1;
    sb.delete();
    tick();
    chk({name, "_valid"}, o_valid, 0);
    chk({name, "_busy"}, o_busy, 0);
    chk({name, "_data"}, o_data, 0);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];

    // Reset state.
    repeat (3) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_data", o_data, 0);
    i_rst = 1'b0;
    tick();

    // Raw capture of a known word.
    do_raw(32'hDEADBEEF, 1'b0);
    wait_idle("raw_deadbeef");

    // Four full samples: sum 128.
    q = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    do_sum(q, 1'b0, 1'b1);
    wait_idle("sum_full4");

    // N=0 means 256 samples: sum 1024.
    q.delete();
    repeat (256) q.push_back(32'h0000000F);
    do_sum(q, 1'b0, 1'b1);
    wait_idle("sum_256");

    // Receiver stalled for 10 cycles: first byte held at 0x00.
    hold = 1'b1;
    tick();
    q = {32'h00000001, 32'h0000FFFF};
    do_sum(q, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, 8'h00);
      tick();
    end
    hold = 1'b0;
    wait_idle("sum_stall");

    // Reset mid-capture.
    send_byte(8'h53);
    send_byte(8'd10);
    repeat (3) begin
      i_dl_valid = 1'b1; i_dl = 32'h0F0F0F0F; tick(); i_dl_valid = 1'b0;
    end
    chk("midcap_busy", o_busy, 1);
    pulse_reset("rst_capture");

    // Reset mid-handshake.
    hold = 1'b1;
    tick();
    q = {32'h000000FF};
    do_sum(q, 1'b0, 1'b1);
    chk("midsend_valid", o_valid, 1);
    pulse_reset("rst_send");
    hold = 1'b0;
    tick();
    do_raw(32'h12345678, 1'b0);
    wait_idle("raw_after_rst");

    // Unknown command byte is ignored.
    send_byte(8'h41);
    tick();
    chk("ign_busy", o_busy, 0);
    chk("ign_valid", o_valid, 0);

    // 'R' bytes injected during capture are dropped.
    q = {32'h00000007, 32'h80000001, 32'hFFFF0000};
    do_sum(q, 1'b1, 1'b1);
    wait_idle("sum_noisy");

    // Randomized command mix.
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_raw($urandom(), 1'b1);
      end else begin
        q.delete();
        repeat ($urandom_range(1, 8)) begin
          case ($urandom_range(0, 3))
            0:       q.push_back(32'h0);
            1:       q.push_back(32'hFFFFFFFF);
            2:       q.push_back((32'h1 << $urandom_range(0, 31)) - 32'h1);
            default: q.push_back($urandom());
          endcase
        end
        do_sum(q, 1'b1, 1'b1);
      end
      wait_idle("rand_cmd");
    end

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
